// File: rtl/raw_pipe_pkg.sv
// Shared definitions for the raw pixel pipeline: capture state encoding,
// pixel width and default geometry. Also used by the demosaic stage.
package raw_pipe_pkg;

  localparam int PIX_W        = 12;
  localparam int H_ACTIVE_DEF = 1280;
  localparam int CNT_W_DEF    = 16;
  localparam int FCNT_W_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } capState_t;

endpackage

// File: rtl/raw_pos_counter.sv
// X/Y position tracker for captured pixels. X/Y hold the position of the
// next pixel to be accepted. X wraps at H_ACTIVE-1 and advances Y. A line
// that ends early (LVAL falls with X not back at 0) forces a new line and
// raises a sticky error that is cleared only when a new frame starts.
module raw_pos_counter
  import raw_pipe_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iClear,
  input  logic             iPixVal,
  input  logic             iLineEnd,
  output logic [CNT_W-1:0] oX,
  output logic [CNT_W-1:0] oY,
  output logic             oLineErr
);

  localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] xReg, yReg, xNext, yNext;
  logic             errReg, errNext;

  // Next position: pixel advance first, then a short-line correction if LVAL
  // dropped before the line wrapped on its own.
  always_comb begin
    xNext   = xReg;
    yNext   = yReg;
    errNext = errReg;
    if (iClear) begin
      xNext   = '0;
      yNext   = '0;
      errNext = 1'b0;
    end else begin
      if (iPixVal) begin
        if (xReg == X_LAST) begin
          xNext = '0;
          yNext = yReg + CNT_ONE;
        end else begin
          xNext = xReg + CNT_ONE;
        end
      end
      if (iLineEnd && (xNext != '0)) begin
        xNext   = '0;
        yNext   = yNext + CNT_ONE;
        errNext = 1'b1;
      end
    end
  end

  // Position and error state registers.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      xReg   <= '0;
      yReg   <= '0;
      errReg <= 1'b0;
    end else begin
      xReg   <= xNext;
      yReg   <= yNext;
      errReg <= errNext;
    end
  end

  assign oX       = xReg;
  assign oY       = yReg;
  assign oLineErr = errReg;

endmodule

// File: rtl/raw_capture_ctrl.sv
// Raw sensor capture sequencer. Qualifies pixels with FVAL/LVAL, gates
// capture with start/stop commands on whole-frame boundaries, and produces
// the pixel strobe plus X/Y position for the line-buffer stage.
// Optional build macro RAW_CAPTURE_FRAME_SKIP_EN adds iSkip: the number of
// complete frames dropped after arming before capture begins.
module raw_capture_ctrl
  import raw_pipe_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int FCNT_W   = FCNT_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [PIX_W-1:0]  iDATA,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic              iSTART,
  input  logic              iEND,
`ifdef RAW_CAPTURE_FRAME_SKIP_EN
  input  logic [3:0]        iSkip,
`endif
  output logic [PIX_W-1:0]  oDATA,
  output logic              oDVAL,
  output logic [CNT_W-1:0]  oX_Cont,
  output logic [CNT_W-1:0]  oY_Cont,
  output logic [FCNT_W-1:0] oFrame_Cont,
  output logic              oBusy,
  output logic              oLine_Err
);

  localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

  capState_t        state, stateNext;
  logic             fval_d, lval_d;
  logic [PIX_W-1:0] data_d;
  logic             stop_pend, stopPendNext;
  logic             run;

  logic             fvalRise, fvalFall, lvalFall;
  logic             pixVal, skipDone, captureStart, frameDone;
  logic [CNT_W-1:0] xPos, yPos;

  // Edges are taken between the live pins and their registered copies.
  assign fvalRise = iFVAL & ~fval_d;
  assign fvalFall = ~iFVAL & fval_d;
  assign lvalFall = ~iLVAL & lval_d;

  // A pixel counts only while capturing and inside both strobes.
  assign pixVal       = (state == ACTIVE) & fval_d & lval_d;
  assign captureStart = (state == ARMED) & ~iEND & fvalRise & skipDone;
  assign frameDone    = (state == ACTIVE) & fvalFall;

  // One register stage on the sensor pins.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      fval_d <= 1'b0;
      lval_d <= 1'b0;
      data_d <= '0;
    end else begin
      fval_d <= iFVAL;
      lval_d <= iLVAL;
      data_d <= iDATA;
    end
  end

`ifdef RAW_CAPTURE_FRAME_SKIP_EN
  logic [3:0] skipCnt;
  logic       skipSeenRise;

  assign skipDone = (skipCnt == 4'd0);

  // Count down whole frames while armed; a frame counts only if its rising
  // edge was seen, so a frame already in flight at arm time is not counted.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      skipCnt      <= 4'd0;
      skipSeenRise <= 1'b0;
    end else if ((state == IDLE) && (stateNext == ARMED)) begin
      skipCnt      <= iSkip;
      skipSeenRise <= 1'b0;
    end else if ((state == ARMED) && !skipDone) begin
      if (fvalRise) begin
        skipSeenRise <= 1'b1;
      end else if (fvalFall && skipSeenRise) begin
        skipCnt      <= skipCnt - 4'd1;
        skipSeenRise <= 1'b0;
      end
    end
  end
`else
  assign skipDone = 1'b1;
`endif

  // Capture FSM next-state logic; a stop request always wins over start.
  always_comb begin
    stateNext    = state;
    stopPendNext = stop_pend;
    case (state)
      IDLE: begin
        stopPendNext = 1'b0;
        if (iSTART && !iEND) stateNext = ARMED;
      end
      ARMED: begin
        stopPendNext = 1'b0;
        if (iEND)              stateNext = IDLE;
        else if (captureStart) stateNext = ACTIVE;
      end
      ACTIVE: begin
        if (iEND)        stopPendNext = 1'b1;
        else if (iSTART) stopPendNext = 1'b0;
        if (fvalFall) begin
          stateNext    = stopPendNext ? IDLE : ARMED;
          stopPendNext = 1'b0;
        end
      end
      default: begin
        stateNext    = IDLE;
        stopPendNext = 1'b0;
      end
    endcase
  end

  // FSM state, pending stop and busy flag.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state     <= IDLE;
      stop_pend <= 1'b0;
      run       <= 1'b0;
    end else begin
      state     <= stateNext;
      stop_pend <= stopPendNext;
      run       <= (stateNext != IDLE);
    end
  end

  raw_pos_counter #(
    .H_ACTIVE (H_ACTIVE),
    .CNT_W    (CNT_W)
  ) uPosCounter (
    .iCLK     (iCLK),
    .iRST_n   (iRST_n),
    .iClear   (captureStart),
    .iPixVal  (pixVal),
    .iLineEnd (lvalFall & (state == ACTIVE)),
    .oX       (xPos),
    .oY       (yPos),
    .oLineErr (oLine_Err)
  );

  // Output pixel, strobe and position registered together.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oDATA   <= '0;
      oDVAL   <= 1'b0;
      oX_Cont <= '0;
      oY_Cont <= '0;
    end else begin
      oDATA <= data_d;
      oDVAL <= pixVal;
      if (captureStart) begin
        oX_Cont <= '0;
        oY_Cont <= '0;
      end else if (pixVal) begin
        oX_Cont <= xPos;
        oY_Cont <= yPos;
      end
    end
  end

  // Completed-frame counter, bumped as a captured frame closes.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oFrame_Cont <= '0;
    end else if (frameDone) begin
      oFrame_Cont <= oFrame_Cont + FCNT_ONE;
    end
  end

  assign oBusy = run;

endmodule

// File: tb/tb_raw_capture_ctrl.sv
// Directed bench for raw_capture_ctrl with an 8-pixel line geometry.
module tb_raw_capture_ctrl;
  import raw_pipe_pkg::*;

  localparam int HA = 8;

  logic              iCLK, iRST_n;
  logic [PIX_W-1:0]  iDATA;
  logic              iFVAL, iLVAL, iSTART, iEND;
`ifdef RAW_CAPTURE_FRAME_SKIP_EN
  logic [3:0]        iSkip;
`endif
  logic [PIX_W-1:0]  oDATA;
  logic              oDVAL;
  logic [15:0]       oX_Cont, oY_Cont;
  logic [31:0]       oFrame_Cont;
  logic              oBusy, oLine_Err;

  int vectors = 0;
  int miscompares = 0;
  logic [43:0] capQ[$];

  raw_capture_ctrl #(.H_ACTIVE(HA), .CNT_W(16), .FCNT_W(32)) dut (
    .iCLK        (iCLK),
    .iRST_n      (iRST_n),
    .iDATA       (iDATA),
    .iFVAL       (iFVAL),
    .iLVAL       (iLVAL),
    .iSTART      (iSTART),
    .iEND        (iEND),
`ifdef RAW_CAPTURE_FRAME_SKIP_EN
    .iSkip       (iSkip),
`endif
    .oDATA       (oDATA),
    .oDVAL       (oDVAL),
    .oX_Cont     (oX_Cont),
    .oY_Cont     (oY_Cont),
    .oFrame_Cont (oFrame_Cont),
    .oBusy       (oBusy),
    .oLine_Err   (oLine_Err)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  // Log every valid output pixel as {data, x, y}.
  always @(negedge iCLK) begin
    if (oDVAL) capQ.push_back({oDATA, oX_Cont, oY_Cont});
  end

  function automatic logic [11:0] pixWord(input int tag, input int ln, input int px);
    return 12'((tag << 8) | (ln << 4) | px);
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic pulse(input logic s, input logic e);
    @(negedge iCLK);
    iSTART = s;
    iEND   = e;
    @(negedge iCLK);
    iSTART = 1'b0;
    iEND   = 1'b0;
  endtask

  // Four-line sensor frame; optional short line and start/end pulses mid-line.
  task automatic driveFrame(input int tag, input int shortLine, input int shortLen,
                            input int startLine, input int endLine);
    capQ.delete();
    @(negedge iCLK);
    iFVAL = 1'b0;
    iLVAL = 1'b0;
    repeat (2) @(negedge iCLK);
    iFVAL = 1'b1;
    repeat (2) @(negedge iCLK);
    for (int ln = 0; ln < 4; ln++) begin
      int len;
      len = (ln == shortLine) ? shortLen : HA;
      for (int px = 0; px < len; px++) begin
        iLVAL  = 1'b1;
        iDATA  = pixWord(tag, ln, px);
        iSTART = (ln == startLine) && (px == 3);
        iEND   = (ln == endLine) && (px == 3);
        @(negedge iCLK);
      end
      iLVAL  = 1'b0;
      iSTART = 1'b0;
      iEND   = 1'b0;
      iDATA  = '0;
      repeat (3) @(negedge iCLK);
    end
    iFVAL = 1'b0;
    repeat (4) @(negedge iCLK);
  endtask

  // Compare the logged pixels against the sensor positions that were driven.
  task automatic checkFrame(input int tag, input bit captured, input int shortLine, input int shortLen);
    logic [43:0] expQ[$];
    if (captured) begin
      for (int ln = 0; ln < 4; ln++) begin
        int len;
        len = (ln == shortLine) ? shortLen : HA;
        for (int px = 0; px < len; px++)
          expQ.push_back({pixWord(tag, ln, px), 16'(px), 16'(ln)});
      end
    end
    check($sformatf("frame%0d_count", tag), 64'(capQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < capQ.size(); i++)
      check($sformatf("frame%0d_pix%0d", tag, i), 64'(capQ[i]), 64'(expQ[i]));
    $display("frame %0d: %0d pixels captured, frame count %0d, busy %0b, line_err %0b",
             tag, capQ.size(), oFrame_Cont, oBusy, oLine_Err);
  endtask

  initial begin
    iRST_n = 1'b0;
    iDATA  = 12'hABC;
    iFVAL  = 1'b1;
    iLVAL  = 1'b1;
    iSTART = 1'b0;
    iEND   = 1'b0;
`ifdef RAW_CAPTURE_FRAME_SKIP_EN
    iSkip  = 4'd0;
`endif
    repeat (3) @(negedge iCLK);
    check("rst_dval", 64'(oDVAL), 64'd0);
    check("rst_data", 64'(oDATA), 64'd0);
    check("rst_busy", 64'(oBusy), 64'd0);
    check("rst_fcnt", 64'(oFrame_Cont), 64'd0);
    check("rst_xy", 64'({oX_Cont, oY_Cont}), 64'd0);
    check("rst_lerr", 64'(oLine_Err), 64'd0);
    $display("reset applied");
    iFVAL  = 1'b0;
    iLVAL  = 1'b0;
    iDATA  = '0;
    iRST_n = 1'b1;
    repeat (2) @(negedge iCLK);

    // Basic capture armed before the frame.
    pulse(1'b1, 1'b0);
    check("start_busy", 64'(oBusy), 64'd1);
    driveFrame(1, -1, 0, -1, -1);
    checkFrame(1, 1'b1, -1, 0);
    check("f1_fcnt", 64'(oFrame_Cont), 64'd1);
    check("f1_busy", 64'(oBusy), 64'd1);

    // Stop while armed, then arm in the middle of a frame.
    pulse(1'b0, 1'b1);
    check("end_armed_busy", 64'(oBusy), 64'd0);
    driveFrame(2, -1, 0, 1, -1);
    checkFrame(2, 1'b0, -1, 0);
    check("f2_fcnt", 64'(oFrame_Cont), 64'd1);
    check("f2_busy", 64'(oBusy), 64'd1);
    driveFrame(3, -1, 0, -1, -1);
    checkFrame(3, 1'b1, -1, 0);
    check("f3_fcnt", 64'(oFrame_Cont), 64'd2);

    // Stop during line 2 of an active frame: frame completes, then idle.
    driveFrame(4, -1, 0, -1, 2);
    checkFrame(4, 1'b1, -1, 0);
    check("f4_fcnt", 64'(oFrame_Cont), 64'd3);
    check("f4_busy", 64'(oBusy), 64'd0);
    driveFrame(5, -1, 0, -1, -1);
    checkFrame(5, 1'b0, -1, 0);
    check("f5_fcnt", 64'(oFrame_Cont), 64'd3);
    check("f5_busy", 64'(oBusy), 64'd0);

    // Short line of 5 pixels, then a clean frame clears the error.
    pulse(1'b1, 1'b0);
    driveFrame(6, 1, 5, -1, -1);
    checkFrame(6, 1'b1, 1, 5);
    check("f6_lerr", 64'(oLine_Err), 64'd1);
    check("f6_fcnt", 64'(oFrame_Cont), 64'd4);
    driveFrame(7, -1, 0, -1, -1);
    checkFrame(7, 1'b1, -1, 0);
    check("f7_lerr", 64'(oLine_Err), 64'd0);
    check("f7_fcnt", 64'(oFrame_Cont), 64'd5);

    // Start and end together from idle: nothing happens.
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    check("both_busy", 64'(oBusy), 64'd0);
    driveFrame(8, -1, 0, -1, -1);
    checkFrame(8, 1'b0, -1, 0);
    check("f8_fcnt", 64'(oFrame_Cont), 64'd5);

    // A start during an active frame cancels an earlier stop request.
    pulse(1'b1, 1'b0);
    driveFrame(9, -1, 0, 2, 1);
    checkFrame(9, 1'b1, -1, 0);
    check("f9_busy", 64'(oBusy), 64'd1);
    check("f9_fcnt", 64'(oFrame_Cont), 64'd6);
    driveFrame(10, -1, 0, -1, -1);
    checkFrame(10, 1'b1, -1, 0);
    check("f10_fcnt", 64'(oFrame_Cont), 64'd7);

`ifdef RAW_CAPTURE_FRAME_SKIP_EN
    // Skip two whole frames after arming.
    pulse(1'b0, 1'b1);
    iSkip = 4'd2;
    pulse(1'b1, 1'b0);
    iSkip = 4'd0;
    driveFrame(11, -1, 0, -1, -1);
    checkFrame(11, 1'b0, -1, 0);
    driveFrame(12, -1, 0, -1, -1);
    checkFrame(12, 1'b0, -1, 0);
    check("skip_fcnt", 64'(oFrame_Cont), 64'd7);
    driveFrame(13, -1, 0, -1, -1);
    checkFrame(13, 1'b1, -1, 0);
    check("f13_fcnt", 64'(oFrame_Cont), 64'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
